uart_text_ctrl: RTL and testbench



---
 rtl/uart_vga_pkg.sv | 13 +
 rtl/uart_text_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_text_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_vga_pkg.sv
// uart_vga_pkg: shared screen geometry, glyph size, control codes and text-controller state type
package uart_vga_pkg;
  localparam int unsigned COLS = 80;
  localparam int unsigned ROWS = 30;
  localparam int unsigned GLYPH_W = 8;
  localparam int unsigned GLYPH_H = 16;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_PUT, ST_SCROLL, ST_SCROLL_CLR} text_state_e;
endpackage

// File: rtl/uart_text_ctrl.sv
// uart_text_ctrl: byte-stream terminal writer into char RAM (rx valid/ready in; ram wr/rd ports, cursor, busy out)
module uart_text_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int ADDR_W = $clog2(COLS*ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [7:0]        ram_rd_data,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);
  import uart_vga_pkg::*;
  localparam logic [ADDR_W-1:0] CELLS_LAST = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(COLS*(ROWS-1));
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS-1);
  text_state_e state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0] wd_q;
  logic copy;
  logic adv;
  logic printable;
  logic last_col;
  logic last_row;
  assign cur_addr = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);
  assign printable = rx_data >= 8'h20 && rx_data <= 8'h7E;
  assign last_col = cursor_col == 7'(COLS-1);
  assign last_row = cursor_row == 5'(ROWS-1);
  assign rx_ready = state == ST_IDLE;
  assign busy = state != ST_IDLE;
  // during the block copy the write data is the RAM read port, one cycle behind the read address
  assign ram_wr_data = copy ? ram_rd_data : wd_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      ram_wr_en <= 1'b0;
      ram_wr_addr <= '0;
      wd_q <= CH_SPACE;
      ram_rd_addr <= '0;
      copy <= 1'b0;
      adv <= 1'b0;
    end else begin
      ram_wr_en <= 1'b0;
      copy <= 1'b0;
      case (state)
        ST_CLEAR: begin
          ram_wr_en <= 1'b1;
          ram_wr_addr <= cnt;
          wd_q <= CH_SPACE;
          cnt <= cnt + ADDR_W'(1);
          if (cnt == CELLS_LAST) begin
            state <= ST_IDLE;
            cnt <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
          end
        end
        ST_IDLE: if (rx_valid) begin
          if (printable) begin
            ram_wr_en <= 1'b1;
            ram_wr_addr <= cur_addr;
            wd_q <= rx_data;
            adv <= 1'b1;
            state <= ST_PUT;
          end else if (rx_data == CH_CR) begin
            cursor_col <= '0;
          end else if (rx_data == CH_LF) begin
            if (last_row) begin
              state <= ST_SCROLL;
              cnt <= '0;
              ram_rd_addr <= ADDR_W'(COLS);
            end else cursor_row <= cursor_row + 5'd1;
          end else if (rx_data == CH_BS && cursor_col != 7'd0) begin
            cursor_col <= cursor_col - 7'd1;
            ram_wr_en <= 1'b1;
            ram_wr_addr <= cur_addr - ADDR_W'(1);
            wd_q <= CH_SPACE;
            adv <= 1'b0;
            state <= ST_PUT;
          end else if (rx_data == CH_FF) begin
            state <= ST_CLEAR;
            cnt <= '0;
          end
        end
        ST_PUT: begin
          state <= ST_IDLE;
          if (adv) begin
            cursor_col <= last_col ? 7'd0 : cursor_col + 7'd1;
            if (last_col && !last_row) cursor_row <= cursor_row + 5'd1;
            if (last_col && last_row) begin
              state <= ST_SCROLL;
              cnt <= '0;
              ram_rd_addr <= ADDR_W'(COLS);
            end
          end
        end
        ST_SCROLL: begin
          // cycle cnt reads cell cnt+COLS; the write of cell cnt lands in the following cycle
          ram_wr_en <= cnt != COPY_LAST;
          copy <= cnt != COPY_LAST;
          ram_wr_addr <= cnt;
          ram_rd_addr <= cnt < COPY_LAST - ADDR_W'(1) ? cnt + ADDR_W'(COLS+1) : ram_rd_addr;
          cnt <= cnt + ADDR_W'(1);
          if (cnt == COPY_LAST) begin
            state <= ST_SCROLL_CLR;
            cnt <= '0;
          end
        end
        ST_SCROLL_CLR: begin
          ram_wr_en <= 1'b1;
          ram_wr_addr <= COPY_LAST + cnt;
          wd_q <= CH_SPACE;
          cnt <= cnt + ADDR_W'(1);
          if (cnt == COL_LAST) begin
            state <= ST_IDLE;
            cnt <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_text_ctrl.sv
// tb_uart_text_ctrl: randomized self-checking bench against a screen-level reference model
`timescale 1ns/1ps
module tb_uart_text_ctrl;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CELLS = COLS*ROWS;
  localparam int LIMIT = 3000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready;
  logic ram_wr_en;
  logic [11:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic [11:0] ram_rd_addr;
  logic [7:0] ram_rd_data = 8'h00;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic busy;
  always #5 clk = ~clk;
  uart_text_ctrl dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );
  logic [7:0] ram [4096];
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int cyc = 0;
  int fill_mode = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill_mode == 1) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'hFF;
    end else if (fill_mode == 2) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'(i);
    end else if (ram_wr_en) begin
      ram[ram_wr_addr] <= ram_wr_data;
      wq_addr.push_back(int'(ram_wr_addr));
      wq_data.push_back(int'(ram_wr_data));
      wq_cyc.push_back(cyc);
    end
    ram_rd_data <= ram[ram_rd_addr];
  end
  logic [7:0] scr [CELLS];
  int mcol = 0;
  int mrow = 0;
  int n_checks = 0;
  int n_fail = 0;
  task check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask
  task tick();
    @(posedge clk);
    #1;
  endtask
  function void m_newline();
    if (mrow < ROWS-1) mrow++;
    else begin
      for (int i = 0; i < CELLS-COLS; i++) scr[i] = scr[i+COLS];
      for (int i = CELLS-COLS; i < CELLS; i++) scr[i] = 8'h20;
    end
  endfunction
  function void m_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mrow*COLS+mcol] = b;
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        m_newline();
      end
    end else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h0A) m_newline();
    else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        scr[mrow*COLS+mcol] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
      mcol = 0;
      mrow = 0;
    end
  endfunction
  task send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data = b;
    while (!rx_ready && n < LIMIT) begin
      tick();
      n++;
    end
    if (n >= LIMIT) check("send.wait", n, 0);
    tick();
    rx_valid = 1'b0;
    m_apply(b);
  endtask
  task wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < LIMIT) begin
      tick();
      n++;
    end
    if (n >= LIMIT) check({tag, ".idle_wait"}, n, 0);
    tick();
  endtask
  task chk_screen(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < CELLS; i++) if (ram[i] !== scr[i]) bad++;
    check({tag, ".screen"}, bad, 0);
    check({tag, ".col"}, int'(cursor_col), mcol);
    check({tag, ".row"}, int'(cursor_row), mrow);
  endtask
  task chk_reset_outs(input string tag);
    check({tag, ".rx_ready"}, int'(rx_ready), 0);
    check({tag, ".busy"}, int'(busy), 1);
    check({tag, ".wr_en"}, int'(ram_wr_en), 0);
    check({tag, ".wr_addr"}, int'(ram_wr_addr), 0);
    check({tag, ".wr_data"}, int'(ram_wr_data), 32);
    check({tag, ".rd_addr"}, int'(ram_rd_addr), 0);
    check({tag, ".col"}, int'(cursor_col), 0);
    check({tag, ".row"}, int'(cursor_row), 0);
  endtask
  task chk_clear(input string tag);
    int base;
    int n;
    int bad;
    base = wq_addr.size();
    n = 0;
    while (!rx_ready && n < LIMIT) begin
      tick();
      n++;
    end
    check({tag, ".cycles"}, n, CELLS);
    tick();
    check({tag, ".writes"}, wq_addr.size() - base, CELLS);
    bad = 0;
    for (int i = 0; i < CELLS && base + i < wq_addr.size(); i++)
      if (wq_addr[base+i] != i || wq_data[base+i] != 32) bad++;
    check({tag, ".order"}, bad, 0);
    for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
    mcol = 0;
    mrow = 0;
    chk_screen(tag);
  endtask
  function automatic logic [7:0] rand_byte();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 70) return 8'($urandom_range(32, 126));
    if (r < 78) return 8'h0A;
    if (r < 84) return 8'h0D;
    if (r < 92) return 8'h08;
    if (r < 94) return 8'h0C;
    return r < 97 ? 8'h7F : 8'(8'h80 | 8'($urandom_range(0, 127)));
  endfunction
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    int base;
    int n;
    int bad;
    fill_mode = 1;
    rx_valid = 1'b1;
    rx_data = 8'h41;
    repeat (3) tick();
    fill_mode = 0;
    chk_reset_outs("reset");
    rx_valid = 1'b0;
    rst = 1'b0;
    chk_clear("init_clear");
    base = wq_addr.size();
    send(8'h41);
    send(8'h42);
    wait_idle("ab");
    check("ab.nwr", wq_addr.size() - base, 2);
    check("ab.addr0", wq_addr[base], 0);
    check("ab.data0", wq_data[base], 8'h41);
    check("ab.addr1", wq_addr[base+1], 1);
    check("ab.data1", wq_data[base+1], 8'h42);
    check("ab.gap", wq_cyc[base+1] - wq_cyc[base], 2);
    check("ab.col", int'(cursor_col), 2);
    check("ab.row", int'(cursor_row), 0);
    send(8'h0D);
    repeat (5) send(8'h0A);
    repeat (79) send(8'($urandom_range(32, 126)));
    wait_idle("prewrap");
    chk_screen("prewrap");
    base = wq_addr.size();
    send(8'h58);
    wait_idle("wrap");
    check("wrap.nwr", wq_addr.size() - base, 1);
    check("wrap.addr", wq_addr[base], 479);
    check("wrap.data", wq_data[base], 8'h58);
    check("wrap.col", int'(cursor_col), 0);
    check("wrap.row", int'(cursor_row), 6);
    chk_screen("wrap");
    send(8'h0C);
    wait_idle("ff");
    chk_screen("ff");
    base = wq_addr.size();
    send(8'h08);
    wait_idle("bs0");
    check("bs0.nwr", wq_addr.size() - base, 0);
    check("bs0.col", int'(cursor_col), 0);
    send(8'h0A);
    send(8'h0A);
    repeat (4) send(8'($urandom_range(32, 126)));
    wait_idle("prebs");
    base = wq_addr.size();
    send(8'h08);
    wait_idle("bs");
    check("bs.nwr", wq_addr.size() - base, 1);
    check("bs.addr", wq_addr[base], 163);
    check("bs.data", wq_data[base], 8'h20);
    check("bs.col", int'(cursor_col), 3);
    check("bs.row", int'(cursor_row), 2);
    chk_screen("bs");
    send(8'h0D);
    repeat (5) send(8'h0A);
    repeat (10) send(8'($urandom_range(32, 126)));
    wait_idle("precr");
    check("precr.col", int'(cursor_col), 10);
    base = wq_addr.size();
    send(8'h0D);
    wait_idle("cr");
    check("cr.nwr", wq_addr.size() - base, 0);
    check("cr.col", int'(cursor_col), 0);
    check("cr.row", int'(cursor_row), 7);
    repeat (22) send(8'h0A);
    repeat (3) send(8'($urandom_range(32, 126)));
    wait_idle("prescroll");
    check("prescroll.col", int'(cursor_col), 3);
    check("prescroll.row", int'(cursor_row), 29);
    fill_mode = 2;
    tick();
    fill_mode = 0;
    for (int i = 0; i < CELLS; i++) scr[i] = 8'(i);
    base = wq_addr.size();
    send(8'h0A);
    n = 0;
    while (busy && n < LIMIT) begin
      tick();
      n++;
    end
    check("scroll.busy_cycles", n, 2401);
    tick();
    check("scroll.nwr", wq_addr.size() - base, CELLS);
    check("scroll.addr0", int'(ram[0]), 8'h50);
    check("scroll.addr2319", int'(ram[2319]), 8'h5F);
    bad = 0;
    for (int i = CELLS - COLS; i < CELLS; i++) if (ram[i] !== 8'h20) bad++;
    check("scroll.lastrow", bad, 0);
    check("scroll.col", int'(cursor_col), 3);
    check("scroll.row", int'(cursor_row), 29);
    chk_screen("scroll");
    send(8'h0C);
    repeat (27) send(8'h0A);
    for (int k = 0; k < 120; k++) begin
      send(rand_byte());
      if (k % 40 == 39) begin
        wait_idle("rand");
        chk_screen($sformatf("rand%0d", k));
      end
    end
    while (mrow < ROWS-1) send(8'h0A);
    send(8'h0A);
    repeat (1000) @(posedge clk);
    #1;
    check("mid.busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk_reset_outs("midscroll");
    repeat (2) tick();
    rst = 1'b0;
    chk_clear("post_reset_clear");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
